reg_writeback_ctrl: RTL and testbench

Write-side controller that drives the register file's single write port (reg_write, dest_address, dest_val).
It merges two result producers into one write per cycle:
- single-cycle ALU results, which cannot be stalled;
- memory load results, which use a valid/ready handshake.
Load results are buffered in a small FIFO. The block enforces write-after-write ordering and traps out-of-range destination addresses.

---
 rtl/reg_writeback_ctrl.sv | 112 +++++++++++
 tb/tb_reg_writeback_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: merges unstallable ALU results and handshaked load results
// into the register file's single write port.
//
// Ports:
//   clk, rst_n                     clock (rising edge), asynchronous active-low reset
//   alu_valid/alu_dest/alu_val     ALU result, no backpressure
//   ld_valid/ld_ready/ld_dest/ld_val  load result, valid/ready handshake
//   reg_write/dest_address/dest_val   registered register-file write port
//   wb_busy                        load FIFO non-empty
//   fifo_count                     load FIFO occupancy, 0..DEPTH
//   addr_err                       sticky flag for an out-of-range destination
module reg_writeback_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 16,
    parameter int DEPTH    = 4,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_val,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_dest,
    input  logic [DATA_W-1:0] ld_val,
    output logic              reg_write,
    output logic [ADDR_W-1:0] dest_address,
    output logic [DATA_W-1:0] dest_val,
    output logic              wb_busy,
    output logic [CW-1:0]     fifo_count,
    output logic              addr_err
);
    localparam logic [ADDR_W:0] NR   = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [ADDR_W-1:0] dest_d [DEPTH];
    logic [DATA_W-1:0] val_q  [DEPTH];
    logic [DATA_W-1:0] val_d  [DEPTH];
    logic [DEPTH-1:0]  kill_q, kill_d;
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              we_q, we_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dval_q, dval_d;
    logic              alu_ok, ld_acc, push, pop;

    assign alu_ok   = alu_valid && ({1'b0, alu_dest} < NR);
    // ld_ready ignores a same-cycle pop, so a full FIFO never pushes.
    assign ld_ready = rst_n && (cnt_q != FULL);
    assign ld_acc   = ld_valid && ld_ready;
    assign push     = ld_acc && ({1'b0, ld_dest} < NR);
    assign pop      = !alu_ok && (cnt_q != '0);

    always_comb begin
        dest_d = dest_q;
        val_d  = val_q;
        kill_d = kill_q;
        // Stale slots may pick up kill bits too; a push always rewrites its kill bit.
        for (int i = 0; i < DEPTH; i++)
            if (alu_ok && dest_q[i] == alu_dest) kill_d[i] = 1'b1;
        if (push) begin
            dest_d[wr_q] = ld_dest;
            val_d[wr_q]  = ld_val;
            kill_d[wr_q] = alu_ok && (ld_dest == alu_dest);
        end
        rd_d   = rd_q + PW'(pop);
        wr_d   = wr_q + PW'(push);
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        we_d   = alu_ok || (pop && !kill_q[rd_q]);
        addr_d = alu_ok ? alu_dest : pop ? dest_q[rd_q] : addr_q;
        dval_d = alu_ok ? alu_val : pop ? val_q[rd_q] : dval_q;
        err_d  = err_q || (alu_valid && !alu_ok) || (ld_acc && !push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_q <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            dval_q <= '0;
            err_q  <= 1'b0;
        end else begin
            kill_q <= kill_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            dval_q <= dval_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        dest_q <= dest_d;
        val_q  <= val_d;
    end

    assign reg_write    = we_q;
    assign dest_address = addr_q;
    assign dest_val     = dval_q;
    assign wb_busy      = cnt_q != '0;
    assign fifo_count   = cnt_q;
    assign addr_err     = err_q;
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: directed self-checking bench for reg_writeback_ctrl.
module tb_reg_writeback_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, ld_valid, ld_ready;
    logic [4:0]  alu_dest, ld_dest, dest_address;
    logic [15:0] alu_val, ld_val, dest_val;
    logic        reg_write, wb_busy, addr_err;
    logic [2:0]  fifo_count;
    int          errs = 0;
    int          checks = 0;
    int          j;

    reg_writeback_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_val(alu_val),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_val(ld_val),
        .reg_write(reg_write), .dest_address(dest_address), .dest_val(dest_val),
        .wb_busy(wb_busy), .fifo_count(fifo_count), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    task automatic alu(input logic [4:0] d, input logic [15:0] v);
        alu_valid = 1'b1;
        alu_dest  = d;
        alu_val   = v;
    endtask

    task automatic ld(input logic [4:0] d, input logic [15:0] v);
        ld_valid = 1'b1;
        ld_dest  = d;
        ld_val   = v;
    endtask

    task automatic wr(input string tag, input logic w, input logic [4:0] a, input logic [15:0] v);
        chk({tag, "_we"}, reg_write, w);
        if (w) begin
            chk({tag, "_addr"}, dest_address, a);
            chk({tag, "_val"}, dest_val, v);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        alu_dest = '0; alu_val = '0; ld_dest = '0; ld_val = '0;
        idle();
        tick();
        tick();
        chk("rst_we", reg_write, 0);
        chk("rst_cnt", fifo_count, 0);
        chk("rst_rdy", ld_ready, 0);
        chk("rst_err", addr_err, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", ld_ready, 1);

        // Basic ALU path: one cycle latency, then holds with reg_write low
        alu(5'd3, 16'h1234);
        tick();
        wr("aluA", 1, 3, 16'h1234);
        idle();
        tick();
        chk("aluA_idle_we", reg_write, 0);
        chk("aluA_hold_addr", dest_address, 3);
        chk("aluA_hold_val", dest_val, 16'h1234);

        // Isolated load: enqueue at edge k, visible after edge k+1
        ld(5'd7, 16'hBEEF);
        tick();
        idle();
        chk("ldB_cnt1", fifo_count, 1);
        chk("ldB_we0", reg_write, 0);
        tick();
        wr("ldB", 1, 7, 16'hBEEF);
        chk("ldB_cnt0", fifo_count, 0);

        // Full/backpressure behind continuous ALU traffic
        j = 0;
        for (int c = 0; c < 8; c++) begin
            alu(5'(8 + c), 16'h0A00 + 16'(c));
            ld_valid = (j < 6);
            ld_dest  = 5'(j);
            ld_val   = 16'hC000 + 16'(j);
            if (ld_valid && ld_ready) j++;
            tick();
            wr("full_alu", 1, 5'(8 + c), 16'h0A00 + 16'(c));
        end
        chk("full_accepted", j, 4);
        chk("full_rdy", ld_ready, 0);
        chk("full_cnt", fifo_count, 4);
        chk("full_busy", wb_busy, 1);
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            wr("drain", 1, 5'(k), 16'hC000 + 16'(k));
            chk("drain_cnt", fifo_count, 3 - k);
        end
        chk("drain_busy", wb_busy, 0);
        ld(5'd4, 16'hC004);
        tick();
        chk("late4_cnt", fifo_count, 1);
        ld(5'd5, 16'hC005);
        tick();
        wr("late4", 1, 4, 16'hC004);
        chk("late5_cnt", fifo_count, 1);
        idle();
        tick();
        wr("late5", 1, 5, 16'hC005);
        chk("late_cnt0", fifo_count, 0);

        // WAW kill of a queued load
        alu(5'd1, 16'h0001); ld(5'd5, 16'hAAAA);
        tick();
        alu(5'd2, 16'h0002); ld(5'd6, 16'hBBBB);
        tick();
        idle();
        alu(5'd5, 16'h5555);
        tick();
        wr("waw_alu", 1, 5, 16'h5555);
        chk("waw_cnt2", fifo_count, 2);
        idle();
        tick();
        chk("waw_killed_we", reg_write, 0);
        chk("waw_cnt1", fifo_count, 1);
        tick();
        wr("waw_keep", 1, 6, 16'hBBBB);
        chk("waw_cnt0", fifo_count, 0);

        // Same-edge ALU and load to one register
        alu(5'd9, 16'h9999); ld(5'd9, 16'h1111);
        tick();
        wr("same_alu", 1, 9, 16'h9999);
        idle();
        tick();
        chk("same_killed_we", reg_write, 0);
        chk("same_cnt0", fifo_count, 0);

        // Illegal ALU destination lets the FIFO pop
        ld(5'd2, 16'h2222);
        tick();
        idle();
        chk("ill_err0", addr_err, 0);
        alu(5'd20, 16'hDEAD);
        tick();
        wr("ill_pop", 1, 2, 16'h2222);
        chk("ill_err1", addr_err, 1);
        chk("ill_cnt0", fifo_count, 0);
        idle();
        tick();
        chk("ill_sticky", addr_err, 1);
        chk("ill_we0", reg_write, 0);

        // Wrap-around: 3*DEPTH loads with steady push/pop
        for (int i = 0; i < 12; i++) begin
            ld(5'(i % 16), 16'h6000 + 16'(i));
            tick();
            if (i == 0) chk("wrap_first_we", reg_write, 0);
            else wr("wrap", 1, 5'((i - 1) % 16), 16'h6000 + 16'(i - 1));
            chk("wrap_cnt", fifo_count, 1);
        end
        idle();
        tick();
        wr("wrap_last", 1, 11, 16'h600B);
        chk("wrap_cnt0", fifo_count, 0);

        // Asynchronous reset mid-operation with 3 queued loads
        for (int i = 0; i < 3; i++) begin
            alu(5'(12 + i), 16'h0E00); ld(5'(1 + i), 16'h7000);
            tick();
        end
        idle();
        chk("pre_rst_cnt", fifo_count, 3);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_we", reg_write, 0);
        chk("arst_cnt", fifo_count, 0);
        chk("arst_rdy", ld_ready, 0);
        chk("arst_addr", dest_address, 0);
        chk("arst_val", dest_val, 0);
        chk("arst_err", addr_err, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("arel_rdy", ld_ready, 1);
        tick();
        tick();
        chk("arel_stale_we", reg_write, 0);
        chk("arel_cnt", fifo_count, 0);

        // Illegal load destination is accepted and dropped
        ld(5'd31, 16'h3131);
        chk("ill_ld_rdy", ld_ready, 1);
        tick();
        idle();
        chk("ill_ld_err", addr_err, 1);
        chk("ill_ld_cnt", fifo_count, 0);
        tick();
        chk("ill_ld_we", reg_write, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
